// File: rtl/gray_updn_counter.sv
// gray_updn_counter: up/down counter that keeps one binary state register and
// publishes both the binary count and its Gray-coded image, both registered so
// they never disagree by a cycle.
//
// Parameters:
//   WIDTH        count width in bits (2..32)
//   SATURATE     0 = wrap at the ends, 1 = hold at the ends
//   RESET_VALUE  binary value loaded by reset (must be < 2**WIDTH)
//
// Ports:
//   clock_i       clock, all state updates on posedge
//   reset_i       asynchronous active-high reset
//   enable_i      advance one step this cycle
//   up_down_i     direction, 1 = up, 0 = down
//   load_i        synchronous load request (wins over enable_i)
//   load_value_i  binary value to load
//   gray_count_o  registered Gray count
//   bin_count_o   registered binary count
//   terminal_o    count sits at the end value for the current direction
//   wrap_pulse_o  one-cycle flag: the count wrapped on the last edge
//
// Build option: define GRAY_COUNTER_LOAD_EN to enable the load path. Without
// it the load ports stay on the interface but are ignored and no load logic
// exists.
module gray_updn_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SATURATE    = 0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] gray_count_o,
  output logic [WIDTH-1:0] bin_count_o,
  output logic             terminal_o,
  output logic             wrap_pulse_o
);

  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ResetGray = ResetBin ^ (ResetBin >> 1);
  localparam logic [WIDTH-1:0] MaxBin    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] One       = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_end;

  // End value depends on the live direction so a turn-around is seen at once.
  assign at_end     = up_down_i ? (bin_q == MaxBin) : (bin_q == '0);
  assign terminal_o = at_end;

`ifndef GRAY_COUNTER_LOAD_EN
  logic unused_load;
  assign unused_load = ^{load_i, load_value_i};
`endif

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
`ifdef GRAY_COUNTER_LOAD_EN
    if (load_i) begin
      bin_d = load_value_i;
    end else
`endif
    if (enable_i) begin
      if (at_end && (SATURATE != 0)) begin
        bin_d = bin_q;
      end else begin
        bin_d  = up_down_i ? (bin_q + One) : (bin_q - One);
        // Any unsaturated step taken from the end value is a wrap.
        wrap_d = at_end;
      end
    end
    // Gray image is derived from the next binary state so both land together.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bin_q  <= ResetBin;
      gray_q <= ResetGray;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_count_o  = bin_q;
  assign gray_count_o = gray_q;
  assign wrap_pulse_o = wrap_q;

endmodule

// File: doc/gray_updn_counter.md
GRAY_UPDN_COUNTER -- requirements
Module: gray_updn_counter

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, count width in bits (legal 2..32).
REQ-002 SHALL provide parameter: SATURATE, 0, 0 = wrap at ends, 1 = hold at ends.
REQ-003 SHALL provide parameter: RESET_VALUE, 0, binary count value loaded on reset (must be < 2^WIDTH).
REQ-004 SHALL provide port: clock  input  1  single clock, all state updates on posedge.
REQ-005 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port: enable  input  1  advance count one step this cycle.
REQ-007 SHALL provide port: up_down  input  1  direction, 1 = up, 0 = down.
REQ-008 SHALL provide port: load  input  1  synchronous load request.
REQ-009 SHALL provide port: load_value  input  WIDTH  binary value to load.
REQ-010 SHALL provide port: gray_count  output  WIDTH  registered Gray-coded count.
REQ-011 SHALL provide port: bin_count  output  WIDTH  registered binary count, same state as gray_count.
REQ-012 SHALL provide port: terminal  output  1  count at end value for current direction.
REQ-013 SHALL provide port: wrap_pulse  output  1  one-cycle flag, count wrapped on last edge.

Function
REQ-014 SHALL hold one internal binary state register; gray_count SHALL equal bin_count ^ (bin_count >> 1) at all times, both registered, never skewed by a cycle.
REQ-015 SHALL prioritise per edge: load > enable > hold.
REQ-016 With enable=1, load=0, up_down=1: bin_count SHALL become bin_count+1 modulo 2^WIDTH.
REQ-017 With enable=1, load=0, up_down=0: bin_count SHALL become bin_count-1 modulo 2^WIDTH.
REQ-018 Every enabled non-saturated step SHALL change exactly one gray_count bit; hold, load and reset are exempt.
REQ-019 SHALL take 1-cycle latency: effect of inputs sampled at edge N visible after edge N.
REQ-020 terminal SHALL be combinational from registered count and up_down: 1 when (up_down=1 and bin_count=2^WIDTH-1) or (up_down=0 and bin_count=0).
REQ-021 SATURATE=0: step from 2^WIDTH-1 up to 0, or from 0 down to 2^WIDTH-1, SHALL set wrap_pulse=1 for exactly the cycle following that edge.
REQ-022 SATURATE=1: enabled step at terminal SHALL leave count unchanged; wrap_pulse SHALL stay 0 permanently.
REQ-023 wrap_pulse SHALL be 0 after any load, hold or non-wrapping step; consecutive wraps (WIDTH=2 not possible back-to-back, any width) SHALL each produce their own pulse.
REQ-024 Direction change mid-count SHALL take effect on the next enabled edge without extra latency.

Reset
REQ-025 Assertion of reset SHALL immediately, without a clock edge, set bin_count=RESET_VALUE, gray_count=Gray(RESET_VALUE), wrap_pulse=0.
REQ-026 While reset is high, enable and load SHALL be ignored; counting SHALL resume on the first posedge after deassertion.
REQ-027 Reset asserted mid-operation SHALL discard any in-progress load or step.

Configuration
REQ-028 Macro GRAY_COUNTER_LOAD_EN defined: load/load_value SHALL operate per REQ-015; loaded value SHALL be taken modulo 2^WIDTH.
REQ-029 Macro GRAY_COUNTER_LOAD_EN undefined: load and load_value ports SHALL remain present but be ignored; no load logic SHALL be synthesised.

Verification
REQ-030 WIDTH=4, SATURATE=0, reset then 16 enables up: gray sequence 0000,0001,0011,...,1000,0000; one bit changes per step; wrap_pulse=1 one cycle after 1000->0000.
REQ-031 WIDTH=4, bin_count=0, up_down=0, enable one cycle: bin_count=15, gray_count=1000, wrap_pulse=1 for one cycle, terminal=0 if up_down stays 0.
REQ-032 WIDTH=4, SATURATE=1, 20 enables up from 0: bin_count holds 15, gray_count 1000, terminal=1, wrap_pulse never 1.
REQ-033 GRAY_COUNTER_LOAD_EN defined, load=1, enable=1, load_value=9: next cycle bin_count=9, gray_count=1101; undefined: count advances by enable only.
REQ-034 RESET_VALUE=0, count at bin 6, reset raised between edges: gray_count=0000 before next posedge; after release, first enable gives 0001.
